rf_cmd_ctrl: RTL and testbench

RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

---
 rtl/rf_cmd_ctrl_if.sv | 41 ++++
 rtl/rf_cmd_ctrl.sv | 153 +++++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_cmd_ctrl_if.sv
// rf_cmd_ctrl_if -- bus bundle between the command controller, the UART-style
// RX/TX byte paths and the register file.
//
// Handshake semantics (all signals sampled on the rising clock edge):
//   RX_D_VLD, RdData_Valid, TX_D_VLD, WrEn, RdEn and RD_Err are single-cycle
//   strobes with no ready/acknowledge.  Each data bus qualified by one of these
//   strobes is meaningful only in the cycle the strobe is high.  TX_Busy is a
//   level: while it is high the transmitter refuses bytes, and the controller
//   holds TX_P_DATA stable until it can issue TX_D_VLD.
//
// Modports:
//   master - the controller (consumes RX/RdData/TX_Busy, drives the rest)
//   slave  - the environment (RX source, register file, transmitter)
interface rf_cmd_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic [WIDTH-1:0] RdData;
  logic             RdData_Valid;
  logic             TX_Busy;
  logic             WrEn;
  logic             RdEn;
  logic [AW-1:0]    Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             CTRL_Busy;
  logic             RD_Err;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CTRL_Busy, RD_Err
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CTRL_Busy, RD_Err
  );
endinterface

// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl -- decodes a byte stream into register-file write/read commands.
//   0xAA, addr, data : write data to addr (WrEn pulse)
//   0xBB, addr       : read addr (RdEn pulse), forward returned byte to TX
// A read that gets no RdData_Valid within RD_TIMEOUT cycles of RdEn is
// abandoned with a one-cycle RD_Err pulse.
//
// Ports:
//   CLK       - clock, rising edge
//   RST_n     - asynchronous active-low reset
//   bus       - rf_cmd_ctrl_if master modport (RX, register file, TX paths)
//   dbg_state - current FSM state encoding (IDLE=0 .. TX_SEND=5)
// Every bus output comes straight from a flop.
module rf_cmd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int RD_TIMEOUT = 4,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLK,
  input  logic                RST_n,
  rf_cmd_ctrl_if.master       bus,
  output logic [2:0]          dbg_state
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic             tx_vld_q, tx_vld_d;
  logic             rd_err_q, rd_err_d;
  logic             busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      rd_err_q  <= rd_err_d;
      busy_q    <= busy_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    rd_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == WIDTH'(8'hAA))      state_d = WR_ADDR;
          else if (bus.RX_P_DATA == WIDTH'(8'hBB)) state_d = RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA[AW-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        // Protected addresses are written too; the register file filters them.
        if (bus.RX_D_VLD) begin
          wdata_d = bus.RX_P_DATA;
          wr_en_d = 1'b1;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA[AW-1:0];
          rd_en_d = 1'b1;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // RD_WAIT is entered on the same edge RdEn rises, so the k-th cycle
        // without data lands cnt on k; RD_Err rises RD_TIMEOUT edges after RdEn.
        if (bus.RdData_Valid) begin
          tx_data_d = bus.RdData;
          state_d   = TX_SEND;
        end else if (cnt_inc == CW'(RD_TIMEOUT)) begin
          cnt_d    = '0;
          rd_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_SEND: begin
        if (!bus.TX_Busy) begin
          tx_vld_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy is registered alongside the state so it tracks state_q exactly.
  assign busy_d = (state_d != IDLE);

  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wdata_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.CTRL_Busy = busy_q;
  assign bus.RD_Err    = rd_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// tb_rf_cmd_ctrl -- directed-vector bench for rf_cmd_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the flops loaded by the preceding edge.
module tb_rf_cmd_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RDT   = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_TX_SEND = 3'd5;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_vec;
  int         n_err;

  rf_cmd_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  rf_cmd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_TIMEOUT(RDT)) dut (
    .CLK      (clk),
    .RST_n    (rst_n),
    .bus      (bus.master),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    tick();
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic check_idle_quiet(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_busy"},  32'(bus.CTRL_Busy), 32'd0);
    check({tag, "_wren"},  32'(bus.WrEn), 32'd0);
    check({tag, "_rden"},  32'(bus.RdEn), 32'd0);
    check({tag, "_txvld"}, 32'(bus.TX_D_VLD), 32'd0);
    check({tag, "_rderr"}, 32'(bus.RD_Err), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input logic [3:0] exp_addr);
    send(8'hAA);
    check({tag, "_busy_cmd"}, 32'(bus.CTRL_Busy), 32'd1);
    send(a);
    send(d);
    check({tag, "_wren"},  32'(bus.WrEn), 32'd1);
    check({tag, "_rden"},  32'(bus.RdEn), 32'd0);
    check({tag, "_addr"},  32'(bus.Address), 32'(exp_addr));
    check({tag, "_wdata"}, 32'(bus.WrData), 32'(d));
    check({tag, "_busy"},  32'(bus.CTRL_Busy), 32'd0);
    tick();
    check({tag, "_wren_off"}, 32'(bus.WrEn), 32'd0);
    check({tag, "_addr_hold"}, 32'(bus.Address), 32'(exp_addr));
    check({tag, "_wdata_hold"}, 32'(bus.WrData), 32'(d));
  endtask

  // Issue 0xBB, addr; leaves the bench one cycle into RdEn being high.
  task automatic start_read(input string tag, input logic [7:0] a);
    send(8'hBB);
    send(a);
    check({tag, "_rden"}, 32'(bus.RdEn), 32'd1);
    check({tag, "_wren"}, 32'(bus.WrEn), 32'd0);
    check({tag, "_addr"}, 32'(bus.Address), 32'(a[3:0]));
    check({tag, "_state"}, 32'(dbg_state), 32'(S_RD_WAIT));
  endtask

  // Return rd data two cycles after the RdEn cycle.
  task automatic return_data(input string tag, input logic [7:0] d);
    tick();
    check({tag, "_rden_off"}, 32'(bus.RdEn), 32'd0);
    tick();
    bus.RdData       = d;
    bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0;
    bus.RdData       = 8'h00;
    check({tag, "_state_tx"}, 32'(dbg_state), 32'(S_TX_SEND));
    check({tag, "_txdata"}, 32'(bus.TX_P_DATA), 32'(d));
    check({tag, "_txvld_early"}, 32'(bus.TX_D_VLD), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.RX_P_DATA    = '0;
    bus.RX_D_VLD     = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.TX_Busy      = 1'b0;

    // reset state
    tick();
    tick();
    check_idle_quiet("rst");
    check("rst_addr",  32'(bus.Address), 32'd0);
    check("rst_wdata", 32'(bus.WrData), 32'd0);
    check("rst_txdata", 32'(bus.TX_P_DATA), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic write
    do_write("wr", 8'h07, 8'h46, 4'd7);

    // read, no backpressure
    start_read("rd", 8'h03);
    return_data("rd", 8'h20);
    tick();
    check("rd_txvld", 32'(bus.TX_D_VLD), 32'd1);
    check("rd_txdata_out", 32'(bus.TX_P_DATA), 32'h20);
    check("rd_busy_done", 32'(bus.CTRL_Busy), 32'd0);
    tick();
    check("rd_txvld_off", 32'(bus.TX_D_VLD), 32'd0);

    // read with TX backpressure; RX bytes arriving meanwhile are dropped
    bus.TX_Busy = 1'b1;
    start_read("bp", 8'h03);
    return_data("bp", 8'h9D);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send(8'hAA);
      else tick();
      check("bp_txvld_hold", 32'(bus.TX_D_VLD), 32'd0);
      check("bp_txdata_hold", 32'(bus.TX_P_DATA), 32'h9D);
      check("bp_state_hold", 32'(dbg_state), 32'(S_TX_SEND));
    end
    bus.TX_Busy = 1'b0;
    tick();
    check("bp_txvld", 32'(bus.TX_D_VLD), 32'd1);
    check("bp_txdata", 32'(bus.TX_P_DATA), 32'h9D);
    tick();
    check("bp_txvld_off", 32'(bus.TX_D_VLD), 32'd0);
    check_idle_quiet("bp_end");

    // read timeout: RD_Err rises exactly RDT cycles after RdEn
    start_read("to", 8'h05);
    for (int k = 1; k < RDT; k++) begin
      tick();
      check("to_err_early", 32'(bus.RD_Err), 32'd0);
      check("to_state_wait", 32'(dbg_state), 32'(S_RD_WAIT));
      check("to_txvld", 32'(bus.TX_D_VLD), 32'd0);
    end
    tick();
    check("to_err", 32'(bus.RD_Err), 32'd1);
    check("to_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("to_txvld_at_err", 32'(bus.TX_D_VLD), 32'd0);
    tick();
    check_idle_quiet("to_end");

    // illegal command byte, then write with upper address bits masked
    send(8'h55);
    check_idle_quiet("ill");
    do_write("mask", 8'hF9, 8'h11, 4'd9);

    // protected address is still written
    do_write("prot", 8'h02, 8'h77, 4'd2);

    // reset mid-frame
    send(8'hAA);
    send(8'h02);
    check("mid_state", 32'(dbg_state), 32'(S_WR_DATA));
    rst_n = 1'b0;
    #1;
    check_idle_quiet("arst");
    check("arst_addr", 32'(bus.Address), 32'd0);
    check("arst_wdata", 32'(bus.WrData), 32'd0);
    check("arst_txdata", 32'(bus.TX_P_DATA), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h33);
    check_idle_quiet("post_rst");
    check("post_rst_addr", 32'(bus.Address), 32'd0);
    check("post_rst_wdata", 32'(bus.WrData), 32'd0);
    tick();
    check("post_rst_wren", 32'(bus.WrEn), 32'd0);

    // decoder live again after reset
    do_write("after", 8'h0C, 8'hE4, 4'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // WrEn and RdEn must never overlap.
  always @(negedge clk) begin
    if (rst_n && (bus.WrEn === 1'b1)) check("excl_wr_rd", 32'(bus.RdEn), 32'd0);
  end

endmodule
